uart_rx_pe: RTL and testbench

Next-generation UART receiver with a built-in baud-tick generator, configurable parity (none/even/odd), a two-flop input synchroniser, false-start rejection, and per-frame error reporting (parity, framing, break). It sits between the `rx` pin and the RX FIFO of the UART system. On each frame it delivers the data word plus three error flags, so the FIFO can store `{brk, frame_err, parity_err, dout}` as one entry.

---
 rtl/states_pkg.sv | 9 +
 rtl/uart_pkg.sv | 12 +
 rtl/baud_gen.sv | 17 +
 rtl/uart_rx_pe.sv | 116 +++++++++++
 tb/tb_uart_rx_pe.sv | 128 ++++++++++++
 5 files changed

// File: rtl/states_pkg.sv
// states_pkg: receiver FSM state codes shared across the UART blocks
// Codes: IDLE, START, DATA, PARITY, STOP as 3-bit constants
package states_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
endpackage

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and per-frame receive status
// Contents: PAR_NONE/PAR_EVEN/PAR_ODD, rx_status_t {brk, frame_err, parity_err}
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_status_t;
endpackage

// File: rtl/baud_gen.sv
// baud_gen: free-running oversampling tick, one pulse every FINAL_VALUE+1 clocks
// Ports: clk, rst_n (async active-low), s_tick (high while counter at terminal count)
module baud_gen #(
  parameter int FINAL_VALUE = 650
) (
  input  logic clk,
  input  logic rst_n,
  output logic s_tick
);
  localparam int W = FINAL_VALUE < 1 ? 1 : $clog2(FINAL_VALUE + 1);
  localparam logic [W-1:0] TOP = W'(FINAL_VALUE);
  logic [W-1:0] q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= (q == TOP) ? '0 : q + 1'b1;
  assign s_tick = q == TOP;
endmodule

// File: rtl/uart_rx_pe.sv
// uart_rx_pe: oversampling UART receiver with parity, framing and break reporting
// Ports: clk, rst_n (async active-low), rx (async serial in, idle high),
//        rx_done (1-clk frame pulse), dout (data word), parity_err, frame_err, brk
module uart_rx_pe
  import states_pkg::*;
  import uart_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int BIT_WIDTH   = 16,
  parameter int SB_TICK     = 16,
  parameter int FINAL_VALUE = 650,
  parameter int PARITY_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic            rx_done,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            brk
);
  localparam int CMAX = SB_TICK > BIT_WIDTH ? SB_TICK : BIT_WIDTH;
  localparam int CW = $clog2(CMAX);
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] HALF_END = CW'(BIT_WIDTH / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_WIDTH - 1);
  localparam logic [CW-1:0] STOP_END = CW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST     = NW'(DBIT - 1);
  localparam logic PAR_ON  = PARITY_MODE != PAR_NONE;
  localparam logic PAR_INV = PARITY_MODE == PAR_ODD;
  logic            rx_m, rx_s, s_tick, p_bit, stop_bit, fin;
  logic [2:0]      state;
  logic [CW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] shreg;
  rx_status_t      st;
  baud_gen #(.FINAL_VALUE(FINAL_VALUE)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_tick (s_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, rx};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      shreg    <= '0;
      p_bit    <= 1'b0;
      stop_bit <= 1'b1;
      fin      <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        START:
          if (s_tick) begin
            if (s_cnt == HALF_END) begin
              // line back high at mid-start means a glitch, not a frame
              state <= rx_s ? IDLE : DATA;
              s_cnt <= '0;
              n_cnt <= '0;
            end else s_cnt <= s_cnt + 1'b1;
          end
        DATA:
          if (s_tick) begin
            if (s_cnt == BIT_END) begin
              shreg <= {rx_s, shreg[DBIT-1:1]};
              s_cnt <= '0;
              if (n_cnt == LAST) state <= PAR_ON ? PARITY : STOP;
              else n_cnt <= n_cnt + 1'b1;
            end else s_cnt <= s_cnt + 1'b1;
          end
        PARITY:
          if (s_tick) begin
            if (s_cnt == BIT_END) begin
              p_bit <= rx_s;
              s_cnt <= '0;
              state <= STOP;
            end else s_cnt <= s_cnt + 1'b1;
          end
        STOP:
          if (s_tick) begin
            // the mid-stop sample decides framing even when more stop ticks follow
            if (s_cnt == BIT_END) stop_bit <= rx_s;
            if (s_cnt == STOP_END) begin
              state <= IDLE;
              fin   <= 1'b1;
            end else s_cnt <= s_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_done <= 1'b0;
      dout    <= '0;
      st      <= '0;
    end else begin
      rx_done <= fin;
      if (fin) begin
        dout <= shreg;
        st   <= '{brk:        ~|shreg & ~stop_bit & ~(PAR_ON & p_bit),
                  frame_err:  ~stop_bit,
                  parity_err: PAR_ON & (^shreg ^ p_bit ^ PAR_INV)};
      end
    end
  assign {brk, frame_err, parity_err} = st;
endmodule

// File: tb/tb_uart_rx_pe.sv
// tb_uart_rx_pe: scoreboard bench for uart_rx_pe in no/even/odd parity builds
module tb_uart_rx_pe;
  import states_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rx = 3'b111;
  logic [2:0]  rx_done, parity_err, frame_err, brk;
  logic [7:0]  dout [3];
  logic [12:0] sb [$];
  logic [12:0] e;
  logic [2:0]  was = 3'b000;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    uart_rx_pe #(
      .DBIT(8), .BIT_WIDTH(16), .SB_TICK(16), .FINAL_VALUE(3), .PARITY_MODE(g)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx[g]),
      .rx_done    (rx_done[g]),
      .dout       (dout[g]),
      .parity_err (parity_err[g]),
      .frame_err  (frame_err[g]),
      .brk        (brk[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic expect_frame(input int i, input logic [7:0] d, input logic b, input logic f, input logic p);
    sb.push_back({2'(i), b, f, p, d});
  endtask
  task automatic bit_time(input int i, input logic b);
    rx[i] = b;
    repeat (64) @(posedge clk);
  endtask
  task automatic send(input int i, input logic [7:0] d, input logic has_par, input logic pb,
                      input logic stop, input int stop_len);
    bit_time(i, 1'b0);
    for (int k = 0; k < 8; k++) bit_time(i, d[k]);
    if (has_par) bit_time(i, pb);
    rx[i] = stop;
    repeat (stop_len) @(posedge clk);
    rx[i] = 1'b1;
    repeat (128) @(posedge clk);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (was[i]) check("rx_done_width", 32'(rx_done[i]), 0);
      if (rx_done[i]) begin
        if (sb.size() == 0) check("sb_pending", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("inst", i, 32'(e[12:11]));
          check("dout", 32'(dout[i]), 32'(e[7:0]));
          check("parity_err", 32'(parity_err[i]), 32'(e[8]));
          check("frame_err", 32'(frame_err[i]), 32'(e[9]));
          check("brk", 32'(brk[i]), 32'(e[10]));
        end
      end
    end
    was = rx_done;
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_rx_done", 32'(rx_done[i]), 0);
      check("rst_dout", 32'(dout[i]), 0);
      check("rst_parity_err", 32'(parity_err[i]), 0);
      check("rst_frame_err", 32'(frame_err[i]), 0);
      check("rst_brk", 32'(brk[i]), 0);
    end
    @(posedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    expect_frame(0, 8'hA5, 0, 0, 0);
    send(0, 8'hA5, 0, 0, 1, 64);
    expect_frame(1, 8'h03, 0, 0, 0);
    send(1, 8'h03, 1, 0, 1, 64);
    expect_frame(1, 8'h03, 0, 0, 1);
    send(1, 8'h03, 1, 1, 1, 64);
    expect_frame(2, 8'h07, 0, 0, 0);
    send(2, 8'h07, 1, 0, 1, 64);
    expect_frame(0, 8'h5A, 0, 1, 0);
    send(0, 8'h5A, 0, 0, 0, 40);
    rx[0] = 1'b0;
    repeat (20) @(posedge clk);
    rx[0] = 1'b1;
    repeat (192) @(posedge clk);
    #1;
    check("false_start_idle", 32'(u[0].dut.state), 32'(IDLE));
    check("false_start_sb", sb.size(), 0);
    expect_frame(0, 8'h3C, 0, 0, 0);
    send(0, 8'h3C, 0, 0, 1, 64);
    check("sb_drained", sb.size(), 0);
    expect_frame(0, 8'h00, 1, 1, 0);
    rx[0] = 1'b0;
    repeat (12 * 64) @(posedge clk);
    rx[0] = 1'b1;
    repeat (96) @(posedge clk);
    #1;
    check("brk_sb", sb.size(), 0);
    check("brk_held", 32'(brk[0]), 1);
    check("brk_frame_err_held", 32'(frame_err[0]), 1);
    check("refire_in_data", 32'(u[0].dut.state), 32'(DATA));
    rst_n = 1'b0;
    #1;
    check("abort_rx_done", 32'(rx_done[0]), 0);
    check("abort_dout", 32'(dout[0]), 0);
    check("abort_parity_err", 32'(parity_err[0]), 0);
    check("abort_frame_err", 32'(frame_err[0]), 0);
    check("abort_brk", 32'(brk[0]), 0);
    check("abort_state", 32'(u[0].dut.state), 32'(IDLE));
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (20 * 64) @(posedge clk);
    check("sb_final", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
